// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared types and helpers for the data memory load/store unit
package data_mem_pkg;
  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;
  typedef enum logic {IDLE, RESP} state_e;
  // H/HU need an even address, W needs a word-aligned address
  function automatic logic is_misaligned(logic [2:0] f3, logic [1:0] off);
    return ((f3[1:0] == 2'b01) && off[0]) || ((f3 == F3_W) && (off != 2'b00));
  endfunction
  // shifting the word down by the byte offset puts the selected lane at bit 0
  function automatic logic [31:0] extend_load(logic [31:0] w, logic [2:0] f3, logic [1:0] off);
    logic [31:0] s;
    s = w >> {off, 3'b000};
    case (f3)
      F3_B:    return {{24{s[7]}}, s[7:0]};
      F3_H:    return {{16{s[15]}}, s[15:0]};
      F3_BU:   return {24'h0, s[7:0]};
      F3_HU:   return {16'h0, s[15:0]};
      default: return w;
    endcase
  endfunction
endpackage

// File: rtl/data_mem_lsu_if.sv
// data_mem_lsu_if: request/response channels between the MEM stage and the load/store unit
// master = requester (pipeline), slave = data_mem_lsu
interface data_mem_lsu_if #(parameter int ADDR_W = 32);
  logic              reqValid;
  logic              reqReady;
  logic [ADDR_W-1:0] addrIn;
  logic [31:0]       dataW;
  logic              memRW;
  logic [2:0]        funct3;
  logic              rValid;
  logic              rReady;
  logic [31:0]       dataR;
  logic              fault;
  modport master (
    output reqValid, addrIn, dataW, memRW, funct3, rReady,
    input  reqReady, rValid, dataR, fault
  );
  modport slave (
    input  reqValid, addrIn, dataW, memRW, funct3, rReady,
    output reqReady, rValid, dataR, fault
  );
endinterface

// File: rtl/data_mem_bank.sv
// data_mem_bank: DEPTH x 32 storage with byte write enables and a synchronous read port
// en: access strobe, we: per-lane write enable, addr: word index,
// wdata: lane-replicated write data, rdata: word registered on en (old contents on a write)
module data_mem_bank #(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic [3:0]               we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);
  logic [31:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (en) begin
      for (int i = 0; i < 4; i++)
        if (we[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      rdata <= mem[addr];
    end
endmodule

// File: rtl/data_mem_lsu.sv
// data_mem_lsu: RV32 data memory with load/store sizing, extension and fault detection
// clk, rstN (async active-low), bus: slave side of data_mem_lsu_if
// One request accepted per cycle; each accepted request yields one response held until rReady.
module data_mem_lsu
  import data_mem_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 32
) (
  input  logic         clk,
  input  logic         rstN,
  data_mem_lsu_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  state_e      state;
  logic        acc, flt, ld_q, flt_q, unused_addr;
  logic [1:0]  off, off_q;
  logic [2:0]  f3, f3_q;
  logic [3:0]  we;
  logic [31:0] wdata, rd;
  assign off = bus.addrIn[1:0];
  assign f3  = bus.funct3;
  assign unused_addr = ^bus.addrIn[ADDR_W-1:AW+2];
  assign bus.reqReady = (state == IDLE) || bus.rReady;
  // gating with rstN keeps the array untouched while reset is held
  assign acc = bus.reqValid && bus.reqReady && rstN;
  assign flt = is_misaligned(f3, off) || (f3 == 3'b011) || (f3[2:1] == 2'b11) || (bus.memRW && f3[2]);
  assign we = (acc && bus.memRW && !flt) ? (f3[1] ? 4'hf : f3[0] ? (off[1] ? 4'hc : 4'h3) : 4'b0001 << off) : 4'h0;
  assign wdata = f3[1] ? bus.dataW : f3[0] ? {2{bus.dataW[15:0]}} : {4{bus.dataW[7:0]}};
  data_mem_bank #(.DEPTH(DEPTH)) u_bank (
    .clk  (clk),
    .en   (acc),
    .we   (we),
    .addr (bus.addrIn[AW+1:2]),
    .wdata(wdata),
    .rdata(rd)
  );
  always_ff @(posedge clk or negedge rstN)
    if (!rstN) begin
      state <= IDLE;
      flt_q <= 1'b0;
      ld_q  <= 1'b0;
      off_q <= 2'b00;
      f3_q  <= 3'b000;
    end else if (acc) begin
      state <= RESP;
      flt_q <= flt;
      ld_q  <= !bus.memRW && !flt;
      off_q <= off;
      f3_q  <= f3;
    end else if (bus.rReady) begin
      state <= IDLE;
    end
  // the bank word only changes on an accept, so the extracted result stays stable while stalled
  assign bus.rValid = (state == RESP);
  assign bus.fault  = flt_q;
  assign bus.dataR  = ld_q ? extend_load(rd, f3_q, off_q) : 32'h0;
endmodule

// File: tb/tb_data_mem_lsu.sv
// tb_data_mem_lsu: directed self-checking bench for data_mem_lsu
module tb_data_mem_lsu;
  logic clk = 1'b0;
  logic rstN = 1'b0;
  int total = 0;
  int bad = 0;
  logic [31:0] held;
  logic [31:0] sexp [4];
  data_mem_lsu_if #(.ADDR_W(32)) bus ();
  data_mem_lsu #(.DEPTH(1024), .ADDR_W(32)) dut (
    .clk (clk),
    .rstN(rstN),
    .bus (bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic op(input string tag, input logic rw, input logic [2:0] f3, input logic [31:0] a,
                    input logic [31:0] d, input logic [31:0] exp_d, input logic exp_f);
    bus.reqValid = 1'b1;
    bus.memRW = rw;
    bus.funct3 = f3;
    bus.addrIn = a;
    bus.dataW = d;
    bus.rReady = 1'b1;
    @(negedge clk);
    chk({tag, "_rdy"}, bus.reqReady, 1);
    chk({tag, "_pre"}, bus.rValid, 0);
    @(posedge clk);
    #1 bus.reqValid = 1'b0;
    @(negedge clk);
    chk({tag, "_v"}, bus.rValid, 1);
    chk({tag, "_d"}, bus.dataR, exp_d);
    chk({tag, "_f"}, bus.fault, exp_f);
    @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
  initial begin
    bus.reqValid = 1'b0;
    bus.memRW = 1'b0;
    bus.funct3 = 3'b010;
    bus.addrIn = 32'h0;
    bus.dataW = 32'h0;
    bus.rReady = 1'b1;
    #12;
    chk("rst_rvalid", bus.rValid, 0);
    chk("rst_data", bus.dataR, 0);
    chk("rst_fault", bus.fault, 0);
    chk("rst_rdy", bus.reqReady, 1);
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;
    op("sw0", 1, 3'b010, 32'h0, 32'ha28b538c, 32'h0, 0);
    op("lw0", 0, 3'b010, 32'h0, 32'h0, 32'ha28b538c, 0);
    op("lb3", 0, 3'b000, 32'h3, 32'h0, 32'hffffffa2, 0);
    op("lbu3", 0, 3'b100, 32'h3, 32'h0, 32'h000000a2, 0);
    op("lh2", 0, 3'b001, 32'h2, 32'h0, 32'hffffa28b, 0);
    op("lhu0", 0, 3'b101, 32'h0, 32'h0, 32'h0000538c, 0);
    op("lb0", 0, 3'b000, 32'h0, 32'h0, 32'hffffff8c, 0);
    op("sb1", 1, 3'b000, 32'h1, 32'hffffff5c, 32'h0, 0);
    op("lw_sb", 0, 3'b010, 32'h0, 32'h0, 32'ha28b5c8c, 0);
    op("sh2", 1, 3'b001, 32'h2, 32'habcd1234, 32'h0, 0);
    op("lw_sh", 0, 3'b010, 32'h0, 32'h0, 32'h12345c8c, 0);
    op("lw_mis", 0, 3'b010, 32'h3, 32'h0, 32'h0, 1);
    op("sh_mis", 1, 3'b001, 32'h1, 32'hffffffff, 32'h0, 1);
    op("f3_011", 0, 3'b011, 32'h0, 32'h0, 32'h0, 1);
    op("sw_f3u", 1, 3'b100, 32'h0, 32'hffffffff, 32'h0, 1);
    op("lw_after", 0, 3'b010, 32'h0, 32'h0, 32'h12345c8c, 0);
    op("sw4", 1, 3'b010, 32'h4, 32'h11111111, 32'h0, 0);
    op("sw8", 1, 3'b010, 32'h8, 32'h22222222, 32'h0, 0);
    op("swc", 1, 3'b010, 32'hc, 32'h33333333, 32'h0, 0);
    // back-pressure: response held three cycles with rReady low
    bus.rReady = 1'b0;
    bus.reqValid = 1'b1;
    bus.memRW = 1'b0;
    bus.funct3 = 3'b010;
    bus.addrIn = 32'h4;
    @(posedge clk);
    #1 bus.reqValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("bp_v%0d", i), bus.rValid, 1);
      chk($sformatf("bp_d%0d", i), bus.dataR, 32'h11111111);
      chk($sformatf("bp_rdy%0d", i), bus.reqReady, 0);
    end
    bus.rReady = 1'b1;
    #1 chk("bp_rdy_rel", bus.reqReady, 1);
    @(posedge clk);
    #1;
    // stream four loads with no bubble
    sexp[0] = 32'h12345c8c;
    sexp[1] = 32'h11111111;
    sexp[2] = 32'h22222222;
    sexp[3] = 32'h33333333;
    bus.reqValid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.addrIn = 32'(i * 4);
      @(posedge clk);
      #1 if (i == 3) bus.reqValid = 1'b0;
      @(negedge clk);
      chk($sformatf("st_v%0d", i), bus.rValid, 1);
      chk($sformatf("st_d%0d", i), bus.dataR, sexp[i]);
    end
    @(negedge clk);
    chk("st_end", bus.rValid, 0);
    // reset during RESP, with a store attempted while reset is held
    bus.rReady = 1'b0;
    bus.reqValid = 1'b1;
    bus.addrIn = 32'h0;
    @(posedge clk);
    #1 bus.reqValid = 1'b0;
    @(negedge clk);
    chk("rr_v", bus.rValid, 1);
    #2 rstN = 1'b0;
    #1 chk("rr_drop", bus.rValid, 0);
    chk("rr_data", bus.dataR, 0);
    bus.reqValid = 1'b1;
    bus.memRW = 1'b1;
    bus.dataW = 32'hdeadbeef;
    bus.rReady = 1'b1;
    @(posedge clk);
    #1 bus.reqValid = 1'b0;
    bus.memRW = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;
    op("rr_lw0", 0, 3'b010, 32'h0, 32'h0, 32'h12345c8c, 0);
    op("wrap", 0, 3'b010, 32'h1000, 32'h0, 32'h12345c8c, 0);
    op("wrap4", 0, 3'b010, 32'h1004, 32'h0, 32'h11111111, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
